// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/writeback
// for a small MIPS-like ISA with CPSR-flag branches, and counts retired instructions.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   input  logic        zero,
   input  logic        flag_v,
   input  logic        flag_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pcsrc,
   output logic        alusrc_a,
   output logic [1:0]  alusrc_b,
   output logic [1:0]  aluop,
   output logic        regdest,
   output logic        memtoreg,
   output logic        regwrite,
   output logic        cpsr_update,
   output logic        cpsr_reset,
   output logic        bformat,
   output logic [2:0]  state,
   output logic        illegal,
   output logic [15:0] instr_cnt
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BVF  = 6'b001101;
   localparam logic [5:0] OP_BEN  = 6'b001110;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_BR  = 3'd5,
      S_JMP = 3'd6,
      S_ILL = 3'd7
   } state_t;

   state_t     cur;
   logic [5:0] op_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= S_IF;
         op_q      <= '0;
         illegal   <= 1'b0;
         instr_cnt <= '0;
      end else begin
         case (cur)
            S_IF:  if (mem_ready) cur <= S_ID;
            S_ID: begin
               op_q <= opcode;
               case (opcode)
                  OP_R, OP_LW, OP_SW, OP_ADDI: cur <= S_EX;
                  OP_BEQ, OP_BVF, OP_BEN:      cur <= S_BR;
                  OP_J:                        cur <= S_JMP;
                  default: begin
                     cur     <= S_ILL;
                     illegal <= 1'b1;
                  end
               endcase
            end
            S_EX:  cur <= (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
            S_MEM: begin
               if (mem_ready) begin
                  if (op_q == OP_SW) begin
                     cur       <= S_IF;
                     instr_cnt <= instr_cnt + 16'd1;
                  end else begin
                     cur <= S_WB;
                  end
               end
            end
            S_WB, S_BR, S_JMP: begin
               cur       <= S_IF;
               instr_cnt <= instr_cnt + 16'd1;
            end
            S_ILL:   cur <= S_ILL;
            default: cur <= S_IF;
         endcase
      end
   end

   assign state = cur;

   // Outputs are Moore in state/op_q except the handshake and branch-condition terms;
   // everything is held low while rst_n is asserted.
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pcsrc       = 2'b00;
      alusrc_a    = 1'b0;
      alusrc_b    = 2'b00;
      aluop       = 2'b00;
      regdest     = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      cpsr_update = 1'b0;
      cpsr_reset  = 1'b0;
      bformat     = 1'b0;
      if (rst_n) begin
         case (cur)
            S_IF: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  alusrc_b = 2'b01;
               end
            end
            S_ID:  alusrc_b = 2'b11;
            S_EX: begin
               alusrc_a    = 1'b1;
               cpsr_update = 1'b1;
               if (op_q == OP_R) begin
                  alusrc_b = 2'b00;
                  aluop    = 2'b10;
               end else begin
                  alusrc_b = 2'b10;
               end
            end
            S_MEM: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               mem_we  = (op_q == OP_SW);
            end
            S_WB: begin
               regwrite = 1'b1;
               regdest  = (op_q == OP_R);
               memtoreg = (op_q == OP_LW);
            end
            S_BR: begin
               alusrc_a   = 1'b1;
               aluop      = 2'b01;
               pcsrc      = 2'b01;
               cpsr_reset = 1'b1;
               bformat    = (op_q == OP_BVF) || (op_q == OP_BEN);
               pc_write   = ((op_q == OP_BEQ) && zero) ||
                            ((op_q == OP_BVF) && flag_v) ||
                            ((op_q == OP_BEN) && flag_n);
            end
            S_JMP: begin
               pcsrc      = 2'b10;
               pc_write   = 1'b1;
               cpsr_reset = 1'b1;
            end
            S_ILL:   cpsr_reset = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: instructions are expanded into per-cycle phase
// plans from the ISA timing rules and every cycle is compared against the expected outputs.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BVF  = 6'b001101;
   localparam logic [5:0] OP_BEN  = 6'b001110;

   typedef struct packed {
      logic       mem_req, mem_we, iord, ir_write, pc_write;
      logic [1:0] pcsrc;
      logic       alusrc_a;
      logic [1:0] alusrc_b, aluop;
      logic       regdest, memtoreg, regwrite, cpsr_update, cpsr_reset, bformat, illegal;
   } outs_t;

   typedef struct {
      outs_t       o;
      logic [2:0]  st;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = '0;
   logic        mem_ready = 1'b0, zero = 1'b0, flag_v = 1'b0, flag_n = 1'b0;
   logic        mem_req, mem_we, iord, ir_write, pc_write, alusrc_a;
   logic [1:0]  pcsrc, alusrc_b, aluop;
   logic        regdest, memtoreg, regwrite, cpsr_update, cpsr_reset, bformat, illegal;
   logic [2:0]  state;
   logic [15:0] instr_cnt;
   outs_t       act;

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_cnt = '0;
   exp_t        exp_q[$];

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .zero(zero), .flag_v(flag_v), .flag_n(flag_n),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pcsrc(pcsrc), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
      .aluop(aluop), .regdest(regdest), .memtoreg(memtoreg), .regwrite(regwrite),
      .cpsr_update(cpsr_update), .cpsr_reset(cpsr_reset), .bformat(bformat),
      .state(state), .illegal(illegal), .instr_cnt(instr_cnt)
   );

   assign act = {mem_req, mem_we, iord, ir_write, pc_write, pcsrc, alusrc_a, alusrc_b,
                 aluop, regdest, memtoreg, regwrite, cpsr_update, cpsr_reset, bformat, illegal};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   // Phases use the architectural state numbers: 0 IF,1 ID,2 EX,3 MEM,4 WB,5 BR,6 JMP,7 ILL.
   function automatic outs_t expect_outs(input int ph, input logic [5:0] op, input logic rdy,
                                         input logic z, input logic v, input logic n);
      outs_t o = '0;
      case (ph)
         0: begin
            o.mem_req = 1'b1;
            if (rdy) begin o.ir_write = 1'b1; o.pc_write = 1'b1; o.alusrc_b = 2'b01; end
         end
         1: o.alusrc_b = 2'b11;
         2: begin
            o.alusrc_a = 1'b1; o.cpsr_update = 1'b1;
            o.alusrc_b = (op == OP_R) ? 2'b00 : 2'b10;
            o.aluop    = (op == OP_R) ? 2'b10 : 2'b00;
         end
         3: begin o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (op == OP_SW); end
         4: begin o.regwrite = 1'b1; o.regdest = (op == OP_R); o.memtoreg = (op == OP_LW); end
         5: begin
            o.alusrc_a = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.cpsr_reset = 1'b1;
            o.bformat  = (op == OP_BVF) || (op == OP_BEN);
            o.pc_write = (op == OP_BEQ && z) || (op == OP_BVF && v) || (op == OP_BEN && n);
         end
         6: begin o.pcsrc = 2'b10; o.pc_write = 1'b1; o.cpsr_reset = 1'b1; end
         7: begin o.illegal = 1'b1; o.cpsr_reset = 1'b1; end
         default: ;
      endcase
      return o;
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("outs", 32'(act), 32'(e.o));
         check("state", 32'(state), 32'(e.st));
         check("instr_cnt", 32'(instr_cnt), 32'(e.cnt));
      end
   end

   // One clock of a plan: drive inputs, queue what the outputs must be this cycle.
   task automatic step(input int ph, input logic [5:0] op, input logic rdy,
                       input logic z, input logic v, input logic n);
      exp_t e;
      opcode    = (ph == 1) ? op : 6'($urandom);
      mem_ready = rdy;
      zero      = z;
      flag_v    = v;
      flag_n    = n;
      e.o   = expect_outs(ph, op, rdy, z, v, n);
      e.st  = 3'(ph);
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      if (ph == 4 || ph == 5 || ph == 6 || (ph == 3 && op == OP_SW && rdy)) exp_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      opcode = 6'($urandom); mem_ready = 1'($urandom);
      zero = 1'($urandom); flag_v = 1'($urandom); flag_n = 1'($urandom);
      #1 rst_n = 1'b0;
      #1;
      check("rst_outs", 32'(act), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_cnt", 32'(instr_cnt), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_cnt = '0;
   endtask

   task automatic run_instr(input logic [5:0] op, input int if_w, input int mem_w,
                            input logic z, input logic v, input logic n, input int abort_idx);
      int   ph_q[$];
      logic rdy_q[$];
      for (int i = 0; i < if_w; i++) begin ph_q.push_back(0); rdy_q.push_back(1'b0); end
      ph_q.push_back(0); rdy_q.push_back(1'b1);
      ph_q.push_back(1); rdy_q.push_back(1'($urandom));
      case (op)
         OP_R, OP_ADDI: begin
            ph_q.push_back(2); rdy_q.push_back(1'($urandom));
            ph_q.push_back(4); rdy_q.push_back(1'($urandom));
         end
         OP_LW, OP_SW: begin
            ph_q.push_back(2); rdy_q.push_back(1'($urandom));
            for (int i = 0; i < mem_w; i++) begin ph_q.push_back(3); rdy_q.push_back(1'b0); end
            ph_q.push_back(3); rdy_q.push_back(1'b1);
            if (op == OP_LW) begin ph_q.push_back(4); rdy_q.push_back(1'($urandom)); end
         end
         OP_BEQ, OP_BVF, OP_BEN: begin ph_q.push_back(5); rdy_q.push_back(1'($urandom)); end
         OP_J: begin ph_q.push_back(6); rdy_q.push_back(1'($urandom)); end
         default: for (int i = 0; i < 20; i++) begin ph_q.push_back(7); rdy_q.push_back(1'($urandom)); end
      endcase
      foreach (ph_q[i]) begin
         if (i == abort_idx) begin
            reset_pulse();
            return;
         end
         if (ph_q[i] == 5) step(ph_q[i], op, rdy_q[i], z, v, n);
         else step(ph_q[i], op, rdy_q[i], 1'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] legal [8];
      legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BVF, OP_BEN};

      @(posedge clk);
      @(posedge clk);
      #1;
      check("por_outs", 32'(act), 32'd0);
      check("por_state", 32'(state), 32'd0);
      check("por_cnt", 32'(instr_cnt), 32'd0);
      rst_n = 1'b1;

      run_instr(OP_LW, 0, 0, 1'b0, 1'b0, 1'b0, -1);
      check("lw_cnt", 32'(instr_cnt), 32'd1);
      run_instr(OP_SW, 1, 3, 1'b0, 1'b0, 1'b0, -1);
      check("sw_cnt", 32'(instr_cnt), 32'd2);
      run_instr(OP_BEQ, 0, 0, 1'b0, 1'b1, 1'b1, -1);
      run_instr(OP_BEQ, 0, 0, 1'b1, 1'b0, 1'b0, -1);
      run_instr(OP_BVF, 2, 0, 1'b0, 1'b1, 1'b0, -1);
      run_instr(OP_BEN, 0, 0, 1'b1, 1'b1, 1'b0, -1);
      run_instr(OP_BEN, 0, 0, 1'b0, 1'b0, 1'b1, -1);
      run_instr(OP_R, 0, 0, 1'b0, 1'b0, 1'b0, -1);
      run_instr(OP_J, 0, 0, 1'b0, 1'b0, 1'b0, -1);
      check("dir_cnt", 32'(instr_cnt), 32'd9);

      for (int k = 0; k < 300; k++)
         run_instr(legal[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), 1'($urandom), -1);

      // abort addi in EX, then sw in the middle of its MEM wait
      run_instr(OP_ADDI, 1, 0, 1'b0, 1'b0, 1'b0, 3);
      run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0, 1'b0, -1);
      check("abort_cnt", 32'(instr_cnt), 32'd1);
      run_instr(OP_SW, 0, 3, 1'b0, 1'b0, 1'b0, 5);
      run_instr(OP_LW, 0, 1, 1'b0, 1'b0, 1'b0, -1);

      run_instr(6'b111111, 0, 0, 1'b0, 1'b0, 1'b0, -1);
      reset_pulse();
      run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0, 1'b0, -1);

      reset_pulse();
      for (int k = 0; k < 65535; k++) run_instr(OP_J, 0, 0, 1'b0, 1'b0, 1'b0, -1);
      check("wrap_pre", 32'(instr_cnt), 32'h0000_FFFF);
      run_instr(OP_J, 0, 0, 1'b0, 1'b0, 1'b0, -1);
      check("wrap_post", 32'(instr_cnt), 32'h0000_0000);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
